// File: rtl/crc32_pkg.sv
// CRC-32 (IEEE 802.3, reflected) constants and byte-update helper.
// Shared by the TX FCS generator and the RX CRC checker.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'h2144DF1C;

  typedef logic [255:0][31:0] crc32_table_t;

  // Elaboration-time build of the byte lookup table from the polynomial.
  function automatic crc32_table_t crc32_gen_table();
    crc32_table_t t;
    logic [31:0]  c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      t[i] = c;
    end
    return t;
  endfunction

  localparam crc32_table_t CRC32_TABLE = crc32_gen_table();

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    return (crc >> 8) ^ CRC32_TABLE[crc[7:0] ^ data];
  endfunction

endpackage

// File: rtl/eth_fcs_gen.sv
// TX Ethernet FCS generator: forwards a frame, zero-pads it to MIN_LEN,
// then appends the CRC-32 FCS least-significant byte first.
module eth_fcs_gen
  import crc32_pkg::*;
#(
  parameter int unsigned MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last
);

  typedef enum logic [1:0] {DATA, PAD, FCS} fcs_state_t;

  fcs_state_t  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;

  logic        load;
  logic [16:0] len_p1;
  logic [31:0] fcs;

  function automatic logic [15:0] len_inc_sat(input logic [15:0] l);
    return (l == 16'hFFFF) ? l : l + 16'd1;
  endfunction

  assign load    = !m_valid_q || m_ready;
  assign s_ready = (state_q == DATA) && load;
  assign len_p1  = {1'b0, len_q} + 17'd1;
  assign fcs     = ~crc_q;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    unique case (state_q)
      DATA: begin
        if (s_valid && s_ready) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_last_d  = 1'b0;
          crc_d     = crc32_byte(crc_q, s_data);
          len_d     = len_inc_sat(len_q);
          if (s_last) begin
            idx_d   = 2'd0;
            state_d = (32'(len_p1) < MIN_LEN) ? PAD : FCS;
          end
        end else if (load) begin
          m_valid_d = 1'b0;
        end
      end
      PAD: begin
        if (load) begin
          m_valid_d = 1'b1;
          m_data_d  = 8'h00;
          m_last_d  = 1'b0;
          crc_d     = crc32_byte(crc_q, 8'h00);
          len_d     = len_inc_sat(len_q);
          if (32'(len_p1) == MIN_LEN) begin
            idx_d   = 2'd0;
            state_d = FCS;
          end
        end
      end
      FCS: begin
        // FCS bytes come from the CRC register, which stops updating here.
        if (load) begin
          m_valid_d = 1'b1;
          m_data_d  = fcs[{idx_q, 3'b000} +: 8];
          m_last_d  = (idx_q == 2'd3);
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DATA;
            crc_d   = CRC32_INIT;
            len_d   = 16'd0;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DATA;
      crc_q     <= CRC32_INIT;
      len_q     <= 16'd0;
      idx_q     <= 2'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_eth_fcs_gen.sv
// Bench for eth_fcs_gen: one instance without padding, one with MIN_LEN=60,
// checked against a bit-serial CRC-32 frame model.
module tb_eth_fcs_gen;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid [2];
  logic       s_ready [2];
  logic [7:0] s_data  [2];
  logic       s_last  [2];
  logic       m_valid [2];
  logic       m_ready [2];
  logic [7:0] m_data  [2];
  logic       m_last  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eth_fcs_gen #(.MIN_LEN(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0])
  );

  eth_fcs_gen #(.MIN_LEN(60)) u_dut60 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-at-a-time reflected CRC-32 over a byte list (not inverted).
  function automatic logic [31:0] crc_bits(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t model(input bq_t d, input int min_len);
    bq_t o = d;
    logic [31:0] f;
    while (o.size() < min_len) o.push_back(8'h00);
    f = ~crc_bits(o);
    for (int k = 0; k < 4; k++) o.push_back(f[8*k +: 8]);
    return o;
  endfunction

  function automatic bq_t rand_frame(input int n);
    bq_t o;
    for (int i = 0; i < n; i++) o.push_back(8'($urandom));
    return o;
  endfunction

  task automatic run_frame(input int sel, input bit rnd, input bq_t din, input bq_t exp, input string tag);
    bq_t        got;
    int         ni = 0;
    int         cyc = 0;
    int         acc_cyc = -1;
    int         out_first = -1;
    int         out_last = -1;
    bit         done = 1'b0;
    bit         stall = 1'b0;
    logic [7:0] sd = 8'h00;
    logic       sl = 1'b0;
    while (!done && cyc < 4000) begin
      @(posedge clk); #1;
      s_valid[sel] = (ni < din.size()) && (!rnd || ($urandom_range(0, 1) == 1));
      s_data[sel]  = (ni < din.size()) ? din[ni] : 8'($urandom);
      s_last[sel]  = (ni == din.size() - 1);
      m_ready[sel] = !rnd || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (stall)
        check($sformatf("%s_hold", tag), {22'h0, m_valid[sel], m_last[sel], m_data[sel]},
              {22'h0, 1'b1, sl, sd});
      stall = m_valid[sel] && !m_ready[sel];
      sd    = m_data[sel];
      sl    = m_last[sel];
      if (s_valid[sel] && s_ready[sel]) begin
        if (ni == 0) acc_cyc = cyc;
        ni++;
      end
      if (m_valid[sel] && m_ready[sel]) begin
        if (out_first < 0) out_first = cyc;
        if (got.size() < exp.size())
          check($sformatf("%s_byte%0d", tag, got.size()), {24'h0, m_data[sel]}, {24'h0, exp[got.size()]});
        check($sformatf("%s_last%0d", tag, got.size()), {31'h0, m_last[sel]},
              {31'h0, (got.size() == exp.size() - 1)});
        got.push_back(m_data[sel]);
        if (m_last[sel] || got.size() > exp.size() + 8) begin
          done = 1'b1;
          out_last = cyc;
        end
      end
      cyc++;
    end
    s_valid[sel] = 1'b0;
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_len"}, got.size(), exp.size());
    check({tag, "_fcs_good"}, ~crc_bits(got), 32'h2144DF1C);
    if (!rnd) begin
      check({tag, "_latency"}, out_first - acc_cyc, 32'd1);
      check({tag, "_gapless"}, out_last - out_first, exp.size() - 1);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_m_valid"}, {31'h0, m_valid[sel]}, 32'd0);
    check({tag, "_m_data"},  {24'h0, m_data[sel]},  32'd0);
    check({tag, "_m_last"},  {31'h0, m_last[sel]},  32'd0);
    check({tag, "_s_ready"}, {31'h0, s_ready[sel]}, 32'd1);
  endtask

  initial begin
    bq_t std9, d, e;
    std9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int s = 0; s < 2; s++) begin
      s_valid[s] = 1'b0; s_data[s] = 8'h00; s_last[s] = 1'b0; m_ready[s] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst60");

    // Known check value and residue-style vector, no padding.
    e = {std9, 8'h26, 8'h39, 8'hF4, 8'hCB};
    run_frame(0, 1'b0, std9, e, "std");
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    e = {d, 8'h1C, 8'hDF, 8'h44, 8'h21};
    run_frame(0, 1'b0, d, e, "zero4");

    // Padding boundaries.
    d = '{8'hAB};
    run_frame(1, 1'b0, d, model(d, 60), "pad1");
    d = rand_frame(59);
    run_frame(1, 1'b0, d, model(d, 60), "pad59");
    d = rand_frame(60);
    run_frame(1, 1'b0, d, model(d, 60), "len60");
    d = rand_frame(61);
    run_frame(1, 1'b0, d, model(d, 60), "len61");

    // Random flow control on both sides.
    e = {std9, 8'h26, 8'h39, 8'hF4, 8'hCB};
    run_frame(0, 1'b1, std9, e, "std_rnd");
    for (int f = 0; f < 4; f++) begin
      d = rand_frame($urandom_range(1, 90));
      run_frame(1, 1'b1, d, model(d, 60), $sformatf("rnd60_%0d", f));
    end
    for (int f = 0; f < 2; f++) begin
      d = rand_frame($urandom_range(1, 40));
      run_frame(0, 1'b1, d, model(d, 0), $sformatf("rnd0_%0d", f));
    end

    // Frame, then a partial frame cut by reset, then a clean frame.
    d = rand_frame(12);
    run_frame(0, 1'b0, d, model(d, 0), "b2b1");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_valid[0] = 1'b1; s_data[0] = 8'($urandom); s_last[0] = 1'b0; m_ready[0] = 1'b1;
    end
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle(0, "midrst");
    e = {std9, 8'h26, 8'h39, 8'hF4, 8'hCB};
    run_frame(0, 1'b0, std9, e, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
